regfile_mp: RTL and testbench

- Parametrised multi-port integer register file for the next-generation (dual-issue capable) RISC-V core.
- Replaces the fixed 2R/1W 32x32 register file.
- Adds:
  - configurable width, depth and port counts
  - deterministic write-port priority
  - optional write-to-read bypass
  - per-register busy scoreboard that the issue stage uses to stall on pending results.
- Sits between decode/issue (read ports, busy set) and writeback (write ports).

---
 rtl/riscv_rf_pkg.sv | 44 ++++
 rtl/rf_scoreboard.sv | 52 +++++
 rtl/regfile_mp.sv | 99 +++++++++
 tb/tb_regfile_mp.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_rf_pkg.sv
`default_nettype none
// ============================================================================
// Module   : riscv_rf_pkg
// Purpose  : Shared constants, types and write-port match helper for the
//            multi-port integer register file.
// Revision : 1.0 - initial release
// ============================================================================
package riscv_rf_pkg;

    localparam int C_DEF_XLEN  = 32;
    localparam int C_DEF_NREGS = 32;

    // Helper operates on write-port vectors padded to these upper bounds.
    localparam int C_MAX_NWR = 8;
    localparam int C_MAX_AW  = 8;
    localparam int C_IDX_W   = $clog2(C_MAX_NWR);

    typedef logic [C_MAX_AW-1:0] rf_addr_t;

    typedef struct packed {
        logic               hit;
        logic [C_IDX_W-1:0] idx;
    } wr_match_t;

    // Later ports overwrite earlier ones, so the highest-index match wins.
    function automatic wr_match_t wr_match(
        input rf_addr_t                       addr,
        input logic [C_MAX_NWR-1:0]           wr_en,
        input logic [C_MAX_NWR*C_MAX_AW-1:0]  wrt_addr
    );
        wr_match_t r;
        r.hit = 1'b0;
        r.idx = '0;
        for (int j = 0; j < C_MAX_NWR; j++) begin
            if (wr_en[j] && (wrt_addr[j*C_MAX_AW +: C_MAX_AW] == addr)) begin
                r.hit = 1'b1;
                r.idx = C_IDX_W'(j);
            end
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rf_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : rf_scoreboard
// Purpose  : Per-register busy bits with set-over-clear priority and the
//            read-port busy lookup.
// Revision : 1.0 - initial release
// ============================================================================
module rf_scoreboard
    import riscv_rf_pkg::*;
#(
    parameter int NREGS    = C_DEF_NREGS,
    parameter int NRD      = 2,
    parameter int AW       = $clog2(NREGS),
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NRD*AW-1:0] rd_addr,
    input  logic [NRD-1:0]    rd_byp,
    input  logic [NREGS-1:0]  wr_hit,
    input  logic              bsy_set,
    input  logic [AW-1:0]     bsy_addr,
    output logic [NRD-1:0]    rd_busy
);

    logic [NREGS-1:0] r_busy;
    logic [NREGS-1:0] w_set;

    always_comb begin
        w_set = '0;
        for (int a = 0; a < NREGS; a++) begin
            w_set[a] = bsy_set && (bsy_addr == AW'(a)) && !((ZERO_REG != 0) && (a == 0));
        end
    end

    // A new producer replaces the completing one, so set beats clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_set | (r_busy & ~wr_hit);
        end
    end

    for (genvar k = 0; k < NRD; k++) begin : g_rd_busy
        logic [AW-1:0] w_ra;
        assign w_ra       = rd_addr[k*AW +: AW];
        assign rd_busy[k] = r_busy[w_ra] & ~rd_byp[k];
    end

endmodule
`default_nettype wire

// File: rtl/regfile_mp.sv
`default_nettype none
// ============================================================================
// Module   : regfile_mp
// Purpose  : Parametrised multi-port integer register file with priority
//            write arbitration, optional bypass and busy scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_mp
    import riscv_rf_pkg::*;
#(
    parameter int XLEN     = C_DEF_XLEN,
    parameter int NREGS    = C_DEF_NREGS,
    parameter int NRD      = 2,
    parameter int NWR      = 1,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1,
    parameter int AW       = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] read,
    output logic [NRD-1:0]      rd_busy,
    input  logic [NWR-1:0]      wr_en,
    input  logic [NWR*AW-1:0]   wrt_addr,
    input  logic [NWR*XLEN-1:0] data,
    input  logic                bsy_set,
    input  logic [AW-1:0]       bsy_addr
);

    logic [XLEN-1:0]                r_mem [NREGS];
    logic [C_MAX_NWR-1:0]           w_wr_en_pad;
    logic [C_MAX_NWR*C_MAX_AW-1:0]  w_wrt_addr_pad;
    wr_match_t                      w_wr_m [NREGS];
    logic [NREGS-1:0]               w_wr_hit;
    logic [NRD-1:0]                 w_byp;

    always_comb begin
        w_wr_en_pad            = '0;
        w_wr_en_pad[NWR-1:0]   = wr_en;
        w_wrt_addr_pad         = '0;
        for (int j = 0; j < NWR; j++) begin
            w_wrt_addr_pad[j*C_MAX_AW +: C_MAX_AW] = rf_addr_t'(wrt_addr[j*AW +: AW]);
        end
    end

    for (genvar a = 0; a < NREGS; a++) begin : g_entry
        assign w_wr_m[a]   = wr_match(rf_addr_t'(a), w_wr_en_pad, w_wrt_addr_pad);
        assign w_wr_hit[a] = w_wr_m[a].hit;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int a = 0; a < NREGS; a++) begin
                r_mem[a] <= '0;
            end
        end else begin
            for (int a = 0; a < NREGS; a++) begin
                if (w_wr_hit[a] && !((ZERO_REG != 0) && (a == 0))) begin
                    r_mem[a] <= data[int'(w_wr_m[a].idx)*XLEN +: XLEN];
                end
            end
        end
    end

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [AW-1:0]   w_ra;
        logic            w_zero;
        wr_match_t       w_m;
        logic [XLEN-1:0] w_rd;

        assign w_ra     = rd_addr[k*AW +: AW];
        assign w_zero   = (ZERO_REG != 0) && (w_ra == '0);
        assign w_m      = wr_match(rf_addr_t'(w_ra), w_wr_en_pad, w_wrt_addr_pad);
        assign w_byp[k] = (BYPASS != 0) && w_m.hit && !w_zero;
        assign w_rd     = w_zero   ? '0 :
                          w_byp[k] ? data[int'(w_m.idx)*XLEN +: XLEN] :
                                     r_mem[w_ra];
        assign read[k*XLEN +: XLEN] = w_rd;
    end

    rf_scoreboard #(
        .NREGS    (NREGS),
        .NRD      (NRD),
        .AW       (AW),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clk      (clk),
        .reset    (reset),
        .rd_addr  (rd_addr),
        .rd_byp   (w_byp),
        .wr_hit   (w_wr_hit),
        .bsy_set  (bsy_set),
        .bsy_addr (bsy_addr),
        .rd_busy  (rd_busy)
    );

endmodule
`default_nettype wire

// File: tb/tb_regfile_mp.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_mp
// Purpose  : Directed self-checking bench for regfile_mp (bypass, no-bypass
//            and scaled 64-bit/4-read configurations).
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_mp;

    logic        clk = 1'b0;
    logic        reset;

    // Shared stimulus for the two 32x32, 2R/2W instances
    logic [9:0]  rd_addr;
    logic [1:0]  wr_en;
    logic [9:0]  wrt_addr;
    logic [63:0] data;
    logic        bsy_set;
    logic [4:0]  bsy_addr;
    logic [63:0] read_a, read_b;
    logic [1:0]  rd_busy_a, rd_busy_b;

    // Scaled instance: XLEN=64, NREGS=64, NRD=4
    logic [23:0]  rd_addr_c;
    logic [0:0]   wr_en_c;
    logic [5:0]   wrt_addr_c;
    logic [63:0]  data_c;
    logic         bsy_set_c;
    logic [5:0]   bsy_addr_c;
    logic [255:0] read_c;
    logic [3:0]   rd_busy_c;

    int          n_tests = 0;
    int          n_fail  = 0;
    string       q_tag [$];
    logic [63:0] q_exp [$];

    always #5 clk = ~clk;

    regfile_mp #(.NWR(2), .BYPASS(1)) dut_a (
        .clk(clk), .reset(reset), .rd_addr(rd_addr), .read(read_a), .rd_busy(rd_busy_a),
        .wr_en(wr_en), .wrt_addr(wrt_addr), .data(data), .bsy_set(bsy_set), .bsy_addr(bsy_addr)
    );

    regfile_mp #(.NWR(2), .BYPASS(0)) dut_b (
        .clk(clk), .reset(reset), .rd_addr(rd_addr), .read(read_b), .rd_busy(rd_busy_b),
        .wr_en(wr_en), .wrt_addr(wrt_addr), .data(data), .bsy_set(bsy_set), .bsy_addr(bsy_addr)
    );

    regfile_mp #(.XLEN(64), .NREGS(64), .NRD(4)) dut_c (
        .clk(clk), .reset(reset), .rd_addr(rd_addr_c), .read(read_c), .rd_busy(rd_busy_c),
        .wr_en(wr_en_c), .wrt_addr(wrt_addr_c), .data(data_c), .bsy_set(bsy_set_c), .bsy_addr(bsy_addr_c)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_en    = '0;
        wrt_addr = '0;
        data     = '0;
        bsy_set  = 1'b0;
        bsy_addr = '0;
    endtask

    task automatic wr(input int p, input logic [4:0] a, input logic [31:0] v);
        wr_en[p]            = 1'b1;
        wrt_addr[p*5 +: 5]  = a;
        data[p*32 +: 32]    = v;
    endtask

    task automatic push(input string tag, input logic [63:0] v);
        q_tag.push_back(tag);
        q_exp.push_back(v);
    endtask

    task automatic check(input logic [63:0] obs);
        string       t;
        logic [63:0] e;
        n_tests++;
        if (q_exp.size() == 0) begin
            n_fail++;
            $display("FAIL queue_empty: observed %h required an expectation", obs);
            return;
        end
        t = q_tag.pop_front();
        e = q_exp.pop_front();
        assert (obs === e) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", t, obs, e);
        end
    endtask

    initial begin
        reset = 1'b1;
        idle();
        rd_addr    = '0;
        rd_addr_c  = '0;
        wr_en_c    = '0;
        wrt_addr_c = '0;
        data_c     = '0;
        bsy_set_c  = 1'b0;
        bsy_addr_c = '0;
        tick();
        tick();
        reset = 1'b0;

        // Reset state
        rd_addr = {5'd5, 5'd5};
        push("rst_read_a", 64'h0);
        push("rst_busy_a", 64'h0);
        push("rst_busy_b", 64'h0);
        push("rst_read_c", 64'h0);
        push("rst_busy_c", 64'h0);
        #4;
        check(read_a);
        check(64'(rd_busy_a));
        check(64'(rd_busy_b));
        check(read_c[63:0]);
        check(64'(rd_busy_c));

        // Write x5, then reset clears it
        tick();
        wr(0, 5'd5, 32'hDEADBEEF);
        tick();
        idle();
        push("wr_x5", 64'hDEADBEEF);
        #4;
        check(64'(read_a[31:0]));
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        push("rst_x5_read", 64'h0);
        push("rst_x5_busy", 64'h0);
        #4;
        check(64'(read_a[31:0]));
        check(64'(rd_busy_a));

        // Write in the same cycle as reset is dropped
        tick();
        reset = 1'b1;
        wr(0, 5'd6, 32'h66);
        tick();
        reset = 1'b0;
        idle();
        rd_addr = {5'd6, 5'd6};
        push("rst_wr_x6", 64'h0);
        #4;
        check(64'(read_a[63:32]));

        // Zero register
        tick();
        wr(0, 5'd0, 32'h12345678);
        rd_addr = {5'd0, 5'd0};
        push("x0_same_p0", 64'h0);
        push("x0_same_p1", 64'h0);
        #4;
        check(64'(read_a[31:0]));
        check(64'(read_a[63:32]));
        tick();
        idle();
        push("x0_next", 64'h0);
        #4;
        check(64'(read_a[31:0]));
        tick();
        bsy_set  = 1'b1;
        bsy_addr = 5'd0;
        tick();
        idle();
        push("x0_busy", 64'h0);
        #4;
        check(64'(rd_busy_a));

        // Bypass versus no bypass
        tick();
        wr(0, 5'd3, 32'h11);
        tick();
        idle();
        wr(0, 5'd3, 32'h22);
        rd_addr = {5'd3, 5'd3};
        push("byp_same_a", 64'h22);
        push("nobyp_same_b", 64'h11);
        #4;
        check(64'(read_a[31:0]));
        check(64'(read_b[31:0]));
        tick();
        idle();
        push("byp_next_a", 64'h22);
        push("nobyp_next_b", 64'h22);
        #4;
        check(64'(read_a[31:0]));
        check(64'(read_b[31:0]));

        // Write conflict: highest-index port wins
        tick();
        wr(0, 5'd7, 32'hAAAA);
        wr(1, 5'd7, 32'hBBBB);
        rd_addr = {5'd7, 5'd7};
        push("conf_byp_a", 64'hBBBB);
        push("conf_nobyp_b", 64'h0);
        #4;
        check(64'(read_a[31:0]));
        check(64'(read_b[31:0]));
        tick();
        idle();
        push("conf_next_a", 64'hBBBB);
        push("conf_next_b", 64'hBBBB);
        #4;
        check(64'(read_a[31:0]));
        check(64'(read_b[63:32]));

        // Scoreboard set / clear / set-wins
        tick();
        bsy_set  = 1'b1;
        bsy_addr = 5'd9;
        tick();
        idle();
        rd_addr = {5'd9, 5'd9};
        push("busy_set_a", 64'h1);
        push("busy_set_b", 64'h1);
        #2;
        check(64'(rd_busy_a[0]));
        check(64'(rd_busy_b[0]));
        wr(0, 5'd9, 32'h5);
        push("wb_busy_a", 64'h0);
        push("wb_busy_b", 64'h1);
        push("wb_byp_a", 64'h5);
        #2;
        check(64'(rd_busy_a[0]));
        check(64'(rd_busy_b[0]));
        check(64'(read_a[31:0]));
        tick();
        idle();
        push("clr_busy_a", 64'h0);
        push("clr_busy_b", 64'h0);
        #4;
        check(64'(rd_busy_a[0]));
        check(64'(rd_busy_b[0]));
        tick();
        bsy_set  = 1'b1;
        bsy_addr = 5'd9;
        wr(1, 5'd9, 32'h6);
        tick();
        idle();
        push("setwin_a", 64'h3);
        push("setwin_b", 64'h3);
        push("setwin_data", 64'h6);
        #4;
        check(64'(rd_busy_a));
        check(64'(rd_busy_b));
        check(64'(read_b[31:0]));

        // Scaled configuration
        tick();
        wr_en_c    = 1'b1;
        wrt_addr_c = 6'd63;
        data_c     = 64'hFFFF_FFFF_0000_0001;
        rd_addr_c  = {4{6'd63}};
        for (int k = 0; k < 4; k++) push($sformatf("wide_byp_p%0d", k), 64'hFFFF_FFFF_0000_0001);
        #4;
        for (int k = 0; k < 4; k++) check(read_c[k*64 +: 64]);
        tick();
        wr_en_c = 1'b0;
        data_c  = '0;
        for (int k = 0; k < 4; k++) push($sformatf("wide_next_p%0d", k), 64'hFFFF_FFFF_0000_0001);
        push("wide_busy", 64'h0);
        #4;
        for (int k = 0; k < 4; k++) check(read_c[k*64 +: 64]);
        check(64'(rd_busy_c));

        if (q_exp.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL leftover: observed %0d unchecked expectations, required 0", q_exp.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
